// File: rtl/alu_control_mdu.sv
// ALU control decoder for the MIPS EX stage with an iterative multiply/divide unit
// that owns the architectural HI/LO registers and stalls the pipeline while it runs.
module alu_control_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [3:0]       alu_ctrl,
   output logic             jr_sel,
   output logic [1:0]       hilo_sel,
   output logic             illegal,
   output logic             stall,
   output logic             busy,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_acc, r_q, r_b;
   logic               r_neg_q, r_neg_r, r_div;

   logic               w_rtype, w_md_op, w_hilo_op, w_signed, w_idle, w_unknown;
   logic               w_launch, w_dbz, w_mthi, w_mtlo, w_hazard;
   logic [WIDTH:0]     w_sum, w_shift, w_trial;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem;

   function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v, input logic sgn);
      f_mag = (sgn && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic neg);
      f_neg = neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      f_neg2 = neg ? -v : v;
   endfunction

   // funct 24..27 are mult/multu/div/divu; 16..19 are mfhi/mthi/mflo/mtlo
   assign w_rtype   = (alu_op == 3'b000);
   assign w_md_op   = w_rtype && (funct[5:2] == 4'b0110);
   assign w_hilo_op = w_rtype && (funct[5:2] == 4'b0100);
   assign w_signed  = ~funct[0];
   assign w_idle    = (r_state == S_IDLE);
   assign w_hazard  = valid_in && (w_md_op || w_hilo_op);
   assign w_dbz     = w_idle && valid_in && w_md_op && funct[1] && (op_b == '0);
   assign w_launch  = w_idle && valid_in && w_md_op && !w_dbz;
   assign w_mthi    = w_idle && valid_in && w_rtype && (funct == 6'd17);
   assign w_mtlo    = w_idle && valid_in && w_rtype && (funct == 6'd19);

   assign busy        = !w_idle;
   assign div_by_zero = w_dbz;
   assign illegal     = valid_in && w_unknown;

   always_comb begin
      alu_ctrl  = 4'b0000;
      jr_sel    = 1'b0;
      hilo_sel  = 2'b00;
      w_unknown = 1'b0;
      if (w_rtype) begin
         case (funct)
            6'd32: alu_ctrl = 4'b0000;
            6'd34: alu_ctrl = 4'b0001;
            6'd36: alu_ctrl = 4'b0010;
            6'd37: alu_ctrl = 4'b0011;
            6'd0:  alu_ctrl = 4'b0100;
            6'd2:  alu_ctrl = 4'b0101;
            6'd42: alu_ctrl = 4'b0111;
            6'd39: alu_ctrl = 4'b1000;
            6'd8:  jr_sel   = 1'b1;
            6'd16: hilo_sel = 2'b01;
            6'd18: hilo_sel = 2'b10;
            6'd17, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: alu_ctrl = 4'b0000;
            default: begin
               alu_ctrl  = 4'b1111;
               w_unknown = 1'b1;
            end
         endcase
      end else begin
         case (alu_op)
            3'b011:  alu_ctrl = 4'b0001;
            3'b101:  alu_ctrl = 4'b0010;
            default: alu_ctrl = 4'b0000;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt = S_BUSY;
               stall       = 1'b1;
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIXUP;
         end
         S_FIXUP: begin
            stall       = w_hazard;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // one radix-2 step: shift-add multiply or restoring divide on magnitudes
   assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
   assign w_shift = {r_acc, r_q[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_b};
   assign w_prod  = f_neg2({r_acc, r_q}, r_neg_q);
   assign w_quo   = f_neg(r_q, r_neg_q);
   assign w_rem   = f_neg(r_acc, r_neg_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_b     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_div   <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_acc   <= '0;
                  r_q     <= f_mag(op_a, w_signed);
                  r_b     <= f_mag(op_b, w_signed);
                  r_neg_q <= w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  r_neg_r <= w_signed && op_a[WIDTH-1];
                  r_div   <= funct[1];
                  r_cnt   <= CNT_W'(WIDTH);
               end else if (w_mthi) begin
                  hi <= op_a;
               end else if (w_mtlo) begin
                  lo <= op_a;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_div) begin
                  if (!w_trial[WIDTH]) begin
                     r_acc <= w_trial[WIDTH-1:0];
                     r_q   <= {r_q[WIDTH-2:0], 1'b1};
                  end else begin
                     r_acc <= w_shift[WIDTH-1:0];
                     r_q   <= {r_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  r_acc <= w_sum[WIDTH:1];
                  r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
               end
            end
            S_FIXUP: begin
               if (r_div) begin
                  hi <= w_rem;
                  lo <= w_quo;
               end else begin
                  hi <= w_prod[2*WIDTH-1:WIDTH];
                  lo <= w_prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode vector table, HI/LO scoreboard for mult/div,
// hazard stall, divide-by-zero, async reset, and an 8-bit instance.
module tb_alu_control_mdu;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        valid_in, jr_sel, illegal, stall, busy, div_by_zero;
   logic [2:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] op_a, op_b, hi, lo;
   logic [3:0]  alu_ctrl;
   logic [1:0]  hilo_sel;

   logic        v8, jr8, ill8, st8, bsy8, dbz8;
   logic [2:0]  aop8;
   logic [5:0]  fn8;
   logic [7:0]  a8, b8, hi8, lo8;
   logic [3:0]  ctrl8;
   logic [1:0]  sel8;

   alu_control_mdu #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op), .funct(funct),
      .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl), .jr_sel(jr_sel), .hilo_sel(hilo_sel),
      .illegal(illegal), .stall(stall), .busy(busy), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   alu_control_mdu #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .valid_in(v8), .alu_op(aop8), .funct(fn8),
      .op_a(a8), .op_b(b8), .alu_ctrl(ctrl8), .jr_sel(jr8), .hilo_sel(sel8),
      .illegal(ill8), .stall(st8), .busy(bsy8), .div_by_zero(dbz8),
      .hi(hi8), .lo(lo8)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] sb_q[$];

   typedef struct {
      logic [2:0] op;
      logic [5:0] fn;
      logic       v;
      logic [3:0] ctrl;
      logic       jr;
      logic [1:0] sel;
      logic       ill;
   } dec_t;
   dec_t tbl[20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_md(input string name, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int n_st;
      int c;
      bit done;
      logic [63:0] e;
      sb_q.push_back(exp);
      @(negedge clk);
      valid_in = 1'b1; alu_op = 3'b000; funct = fn; op_a = a; op_b = b;
      #1 n_st = stall ? 1 : 0;
      @(posedge clk);
      #1 valid_in = 1'b0;
      done = 1'b0;
      for (c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         if (stall) n_st++;
      end
      chk({name, " done"}, 64'(done), 64'd1);
      chk({name, " stalls"}, 64'(n_st), 64'd33);
      chk({name, " latency"}, 64'(c + 1), 64'd34);
      e = sb_q.pop_front();
      chk({name, " hi:lo"}, {hi, lo}, e);
   endtask

   task automatic mt(input logic [5:0] fn, input logic [31:0] a);
      @(negedge clk);
      valid_in = 1'b1; alu_op = 3'b000; funct = fn; op_a = a;
      #1 chk("mt stall", 64'(stall), 64'd0);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int c;
      bit done;
      logic [63:0] e;

      tbl[0]  = '{3'b000, 6'd32, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{3'b000, 6'd34, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{3'b000, 6'd36, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
      tbl[3]  = '{3'b000, 6'd37, 1'b0, 4'h3, 1'b0, 2'd0, 1'b0};
      tbl[4]  = '{3'b000, 6'd0,  1'b0, 4'h4, 1'b0, 2'd0, 1'b0};
      tbl[5]  = '{3'b000, 6'd2,  1'b0, 4'h5, 1'b0, 2'd0, 1'b0};
      tbl[6]  = '{3'b000, 6'd42, 1'b0, 4'h7, 1'b0, 2'd0, 1'b0};
      tbl[7]  = '{3'b000, 6'd39, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0};
      tbl[8]  = '{3'b000, 6'd8,  1'b0, 4'h0, 1'b1, 2'd0, 1'b0};
      tbl[9]  = '{3'b000, 6'd5,  1'b1, 4'hF, 1'b0, 2'd0, 1'b1};
      tbl[10] = '{3'b000, 6'd5,  1'b0, 4'hF, 1'b0, 2'd0, 1'b0};
      tbl[11] = '{3'b000, 6'd16, 1'b1, 4'h0, 1'b0, 2'd1, 1'b0};
      tbl[12] = '{3'b000, 6'd18, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0};
      tbl[13] = '{3'b000, 6'd17, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
      tbl[14] = '{3'b001, 6'd5,  1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
      tbl[15] = '{3'b011, 6'd5,  1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
      tbl[16] = '{3'b100, 6'd0,  1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
      tbl[17] = '{3'b101, 6'd0,  1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
      tbl[18] = '{3'b010, 6'd42, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
      tbl[19] = '{3'b111, 6'd5,  1'b0, 4'h0, 1'b0, 2'd0, 1'b0};

      rst_n = 1'b0;
      valid_in = 1'b0; alu_op = 3'b000; funct = 6'd0; op_a = '0; op_b = '0;
      v8 = 1'b0; aop8 = 3'b000; fn8 = 6'd0; a8 = '0; b8 = '0;
      #12;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst stall", 64'(stall), 64'd0);
      chk("rst dbz", 64'(div_by_zero), 64'd0);
      chk("rst hi:lo", {hi, lo}, 64'd0);
      chk("rst8 hi:lo", 64'({hi8, lo8}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         alu_op = tbl[i].op; funct = tbl[i].fn; valid_in = tbl[i].v;
         #1;
         chk($sformatf("dec%0d alu_ctrl", i), 64'(alu_ctrl), 64'(tbl[i].ctrl));
         chk($sformatf("dec%0d jr_sel", i), 64'(jr_sel), 64'(tbl[i].jr));
         chk($sformatf("dec%0d hilo_sel", i), 64'(hilo_sel), 64'(tbl[i].sel));
         chk($sformatf("dec%0d illegal", i), 64'(illegal), 64'(tbl[i].ill));
      end
      @(negedge clk);
      valid_in = 1'b0; alu_op = 3'b000; funct = 6'd0;

      run_md("mult",  6'd24, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      run_md("multu", 6'd25, 32'd7, 32'hFFFF_FFFD, 64'h0000_0006_FFFF_FFEB);
      run_md("divu",  6'd27, 32'd100, 32'd7, {32'd2, 32'd14});
      run_md("div-7/2", 6'd26, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      run_md("divmin", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run_md("div7/-2", 6'd26, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run_md("divu big", 6'd27, 32'hFFFF_FFFF, 32'h10, 64'h0000_000F_0FFF_FFFF);

      mt(6'd17, 32'h11);
      chk("mthi 11", 64'(hi), 64'h11);
      mt(6'd19, 32'h22);
      chk("mtlo 22", 64'(lo), 64'h22);
      @(negedge clk);
      valid_in = 1'b1; alu_op = 3'b000; funct = 6'd26; op_a = 32'd5; op_b = 32'd0;
      #1;
      chk("dbz pulse", 64'(div_by_zero), 64'd1);
      chk("dbz stall", 64'(stall), 64'd0);
      @(negedge clk);
      chk("dbz busy", 64'(busy), 64'd0);
      valid_in = 1'b0;
      #1 chk("dbz drop", 64'(div_by_zero), 64'd0);
      chk("dbz hi:lo", {hi, lo}, {32'h11, 32'h22});

      mt(6'd17, 32'hABCD);
      chk("mthi ABCD", 64'(hi), 64'hABCD);

      sb_q.push_back({32'd3, 32'd0});
      @(negedge clk);
      valid_in = 1'b1; alu_op = 3'b000; funct = 6'd24; op_a = 32'h1_0000; op_b = 32'h3_0000;
      @(posedge clk);
      #1 valid_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 valid_in = 1'b1; funct = 6'd16;
      n = 0; done = 1'b0;
      for (c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      chk("mfhi released", 64'(done), 64'd1);
      chk("mfhi stalls", 64'(n), 64'd31);
      chk("mfhi busy", 64'(busy), 64'd0);
      chk("mfhi hilo_sel", 64'(hilo_sel), 64'd1);
      e = sb_q.pop_front();
      chk("mfhi hi:lo", {hi, lo}, e);
      valid_in = 1'b0;

      mt(6'd19, 32'h55);
      @(negedge clk);
      valid_in = 1'b1; alu_op = 3'b000; funct = 6'd25; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk);
      #1 valid_in = 1'b0;
      repeat (4) @(posedge clk);
      chk("pre-rst busy", 64'(busy), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst busy", 64'(busy), 64'd0);
      chk("arst stall", 64'(stall), 64'd0);
      chk("arst hi:lo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post-rst busy", 64'(busy), 64'd0);
      chk("post-rst hi:lo", {hi, lo}, 64'd0);

      sb_q.push_back(64'h0000_0000_0000_FFF1);
      @(negedge clk);
      v8 = 1'b1; aop8 = 3'b000; fn8 = 6'd24; a8 = 8'd5; b8 = 8'hFD;
      #1 n = st8 ? 1 : 0;
      @(posedge clk);
      #1 v8 = 1'b0;
      done = 1'b0;
      for (c = 0; c < 30; c++) begin
         @(negedge clk);
         if (!bsy8) begin
            done = 1'b1;
            break;
         end
         if (st8) n++;
      end
      chk("w8 done", 64'(done), 64'd1);
      chk("w8 stalls", 64'(n), 64'd9);
      chk("w8 latency", 64'(c + 1), 64'd10);
      e = sb_q.pop_front();
      chk("w8 hi:lo", 64'({hi8, lo8}), e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
